load_store_unit: RTL and testbench

Memory-stage load/store unit directly downstream of the execute stage in the 3-stage pipeline. It consumes the execute stage's ALU result (effective address) and forwarded rs2 value (store data), and runs one data-bus transaction per access over a valid/ready request and valid response bus that serves data RAM and UART MMIO. It stalls the pipeline until the access completes and returns aligned, sign- or zero-extended load data to writeback.

---
 rtl/load_store_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Memory-stage load/store unit. Takes the effective address and store data
// from execute, performs one transaction on a valid/ready request, valid
// response data bus, stalls the upstream pipeline while the access is in
// flight, and returns aligned, sign/zero-extended load data.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned H/HU/W accesses skip the bus, go straight to DONE
//               and pulse misalign_o.
//   undefined : misalignment is ignored. The offending low address bits are
//               cleared and the access runs normally. misalign_o is tied to 0.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   mem_rd, mem_wr    load / store request from execute (store wins)
//   mem_type          funct3 access size/sign (B,H,W,BU,HU)
//   addr, wdata       effective address, store data
//   stall_o           holds fetch/decode/execute
//   req_*             bus request channel (valid/ready)
//   rsp_valid_i/rdata bus read response
//   load_data_o       extended load result, held until next load completes
//   load_valid_o      one-cycle pulse when a load completes
//   misalign_o        one-cycle misaligned-access pulse (trap build only)
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  input  logic [2:0]           mem_type,
  input  logic [BUS_WIDTH-1:0] addr,
  input  logic [BUS_WIDTH-1:0] wdata,
  output logic                 stall_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic                 req_we_o,
  output logic [BUS_WIDTH-1:0] req_addr_o,
  output logic [BUS_WIDTH-1:0] req_wdata_o,
  output logic [3:0]           req_be_o,
  input  logic                 rsp_valid_i,
  input  logic [BUS_WIDTH-1:0] rsp_rdata_i,
  output logic [BUS_WIDTH-1:0] load_data_o,
  output logic                 load_valid_o,
  output logic                 misalign_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t               state_q, state_d;
  logic                 we_q, we_d;
  logic [BUS_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [1:0]           off_q, off_d;
  logic [BUS_WIDTH-1:0] ld_q, ld_d;

  // Decoded incoming access
  logic [1:0]           in_size;
  logic                 in_uns;
  logic [1:0]           in_off;
  logic [3:0]           in_be;
  logic [BUS_WIDTH-1:0] in_wdata;
  logic                 access;

  // Load extraction
  logic [7:0]           byte_lane [4];
  logic [7:0]           sel_byte;
  logic [15:0]          sel_half;
  logic [BUS_WIDTH-1:0] ext_data;

  assign access = mem_rd || mem_wr;

  // funct3 decode; 011 and 11x fall through to word.
  always_comb begin
    in_size = SZ_W;
    in_uns  = 1'b0;
    unique case (mem_type)
      3'b000:  begin in_size = SZ_B; in_uns = 1'b0; end
      3'b001:  begin in_size = SZ_H; in_uns = 1'b0; end
      3'b100:  begin in_size = SZ_B; in_uns = 1'b1; end
      3'b101:  begin in_size = SZ_H; in_uns = 1'b1; end
      default: begin in_size = SZ_W; in_uns = 1'b0; end
    endcase
  end

  // Lane offset, byte enables and replicated store data. Clearing the low
  // offset bits for H/W is what makes a non-trapping misaligned access
  // behave as the aligned access below it.
  always_comb begin
    in_off   = addr[1:0];
    in_be    = 4'b1111;
    in_wdata = wdata;
    unique case (in_size)
      SZ_B: begin
        in_off   = addr[1:0];
        in_be    = 4'b0001 << addr[1:0];
        in_wdata = {4{wdata[7:0]}};
      end
      SZ_H: begin
        in_off   = {addr[1], 1'b0};
        in_be    = addr[1] ? 4'b1100 : 4'b0011;
        in_wdata = {2{wdata[15:0]}};
      end
      default: begin
        in_off   = 2'b00;
        in_be    = 4'b1111;
        in_wdata = wdata;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic in_mis;
  assign in_mis = ((in_size == SZ_H) && addr[0]) ||
                  ((in_size == SZ_W) && (addr[1:0] != 2'b00));
`endif

  // Split the response word into byte lanes for offset selection.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_lane[gi] = rsp_rdata_i[8*gi +: 8];
  end

  assign sel_byte = byte_lane[off_q];
  assign sel_half = off_q[1] ? rsp_rdata_i[31:16] : rsp_rdata_i[15:0];

  always_comb begin
    ext_data = rsp_rdata_i;
    unique case (size_q)
      SZ_B:    ext_data = uns_q ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      SZ_H:    ext_data = uns_q ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: ext_data = rsp_rdata_i;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    ld_d    = ld_q;
`ifdef MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (access) begin
          we_d    = mem_wr;
          addr_d  = {addr[BUS_WIDTH-1:2], 2'b00};
          wdata_d = in_wdata;
          be_d    = in_be;
          size_d  = in_size;
          uns_d   = in_uns;
          off_d   = in_off;
          state_d = S_REQ;
`ifdef MISALIGN_TRAP_EN
          mis_d   = in_mis;
          if (in_mis) state_d = S_DONE;
`endif
        end
      end
      S_REQ: begin
        // Stores are posted: no response is expected.
        if (req_ready_i) state_d = we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (rsp_valid_i) begin
          ld_d    = ext_data;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      ld_q    <= '0;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      ld_q    <= ld_d;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign stall_o = !rst && ((state_q == S_IDLE && access) ||
                            state_q == S_REQ || state_q == S_WAIT);

  assign req_valid_o = (state_q == S_REQ);
  assign req_we_o    = we_q;
  assign req_addr_o  = addr_q;
  assign req_wdata_o = wdata_q;
  assign req_be_o    = be_q;
  assign load_data_o = ld_q;

`ifdef MISALIGN_TRAP_EN
  assign load_valid_o = (state_q == S_DONE) && !we_q && !mis_q;
  assign misalign_o   = (state_q == S_DONE) && mis_q;
`else
  assign load_valid_o = (state_q == S_DONE) && !we_q;
  assign misalign_o   = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        mem_rd, mem_wr;
    logic [2:0]  mem_type;
    logic [31:0] addr, wdata;
    logic        stall_o, req_valid_o, req_ready_i, req_we_o;
    logic [31:0] req_addr_o, req_wdata_o;
    logic [3:0]  req_be_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_rdata_i, load_data_o;
    logic        load_valid_o, misalign_o;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.BUS_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_type(mem_type), .addr(addr), .wdata(wdata), .stall_o(stall_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_we_o(req_we_o),
        .req_addr_o(req_addr_o), .req_wdata_o(req_wdata_o), .req_be_o(req_be_o),
        .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i),
        .load_data_o(load_data_o), .load_valid_o(load_valid_o),
        .misalign_o(misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        errors++;
        $error("FAIL timeout: stimulus did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic run_load(input string nm, input logic [2:0] t,
                            input logic [31:0] a, input logic [31:0] word,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_data);
        mem_rd = 1'b1; mem_type = t; addr = a; req_ready_i = 1'b1;
        #1;
        chk({nm, "_idle_stall"}, stall_o, 1'b1);
        @(negedge clk);
        mem_rd = 1'b0;
        chk({nm, "_req_valid"}, req_valid_o, 1'b1);
        chk({nm, "_req_we"}, req_we_o, 1'b0);
        chk({nm, "_req_addr"}, req_addr_o, exp_addr);
        chk({nm, "_req_be"}, req_be_o, exp_be);
        rsp_valid_i = 1'b1; rsp_rdata_i = ~word;
        @(negedge clk);
        chk({nm, "_wait_valid"}, req_valid_o, 1'b0);
        chk({nm, "_wait_stall"}, stall_o, 1'b1);
        chk({nm, "_wait_lvalid"}, load_valid_o, 1'b0);
        rsp_valid_i = 1'b1; rsp_rdata_i = word;
        @(negedge clk);
        rsp_valid_i = 1'b0; rsp_rdata_i = 32'h0;
        chk({nm, "_done_lvalid"}, load_valid_o, 1'b1);
        chk({nm, "_done_data"}, load_data_o, exp_data);
        chk({nm, "_done_stall"}, stall_o, 1'b0);
        chk({nm, "_done_mis"}, misalign_o, 1'b0);
        @(negedge clk);
        chk({nm, "_idle_lvalid"}, load_valid_o, 1'b0);
        chk({nm, "_idle_hold"}, load_data_o, exp_data);
        $display("load %s addr=0x%0h data=0x%0h", nm, a, load_data_o);
    endtask

    initial begin
        rst = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; mem_type = 3'b000;
        addr = 32'h0; wdata = 32'h0; req_ready_i = 1'b0;
        rsp_valid_i = 1'b0; rsp_rdata_i = 32'h0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_req_valid", req_valid_o, 1'b0);
        chk("rst_req_we", req_we_o, 1'b0);
        chk("rst_req_addr", req_addr_o, 32'h0);
        chk("rst_req_wdata", req_wdata_o, 32'h0);
        chk("rst_req_be", req_be_o, 4'b0000);
        chk("rst_load_data", load_data_o, 32'h0);
        chk("rst_load_valid", load_valid_o, 1'b0);
        chk("rst_misalign", misalign_o, 1'b0);
        rst = 1'b0; mem_rd = 1'b0;
        @(negedge clk);

        mem_wr = 1'b1; mem_type = 3'b000; addr = 32'h1003; wdata = 32'h000000A5;
        req_ready_i = 1'b1;
        #1;
        chk("sb_idle_stall", stall_o, 1'b1);
        @(negedge clk);
        mem_wr = 1'b0;
        chk("sb_req_valid", req_valid_o, 1'b1);
        chk("sb_req_we", req_we_o, 1'b1);
        chk("sb_req_be", req_be_o, 4'b1000);
        chk("sb_req_addr", req_addr_o, 32'h00001000);
        chk("sb_req_wdata", req_wdata_o, 32'hA5A5A5A5);
        chk("sb_req_stall", stall_o, 1'b1);
        @(negedge clk);
        chk("sb_done_valid", req_valid_o, 1'b0);
        chk("sb_done_stall", stall_o, 1'b0);
        chk("sb_done_lvalid", load_valid_o, 1'b0);
        @(negedge clk);
        chk("sb_idle2_stall", stall_o, 1'b0);
        $display("store sb addr=0x1003");

        run_load("lb",  3'b000, 32'h2001, 32'h12348056, 32'h2000, 4'b0010, 32'hFFFFFF80);
        run_load("lbu", 3'b100, 32'h2001, 32'h12348056, 32'h2000, 4'b0010, 32'h00000080);
        run_load("lhu", 3'b101, 32'h2002, 32'hBEEF1234, 32'h2000, 4'b1100, 32'h0000BEEF);
        run_load("lh",  3'b001, 32'h2002, 32'hBEEF1234, 32'h2000, 4'b1100, 32'hFFFFBEEF);

        mem_wr = 1'b1; mem_type = 3'b010; addr = 32'h3000; wdata = 32'hDEADBEEF;
        req_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_wr = 1'b0;
            req_ready_i = (i == 5);
            #1;
            chk("sw_hold_valid", req_valid_o, 1'b1);
            chk("sw_hold_addr", req_addr_o, 32'h00003000);
            chk("sw_hold_wdata", req_wdata_o, 32'hDEADBEEF);
            chk("sw_hold_be", req_be_o, 4'b1111);
            chk("sw_hold_we", req_we_o, 1'b1);
            chk("sw_hold_stall", stall_o, 1'b1);
        end
        @(negedge clk);
        req_ready_i = 1'b1;
        chk("sw_done_valid", req_valid_o, 1'b0);
        chk("sw_done_stall", stall_o, 1'b0);
        @(negedge clk);
        $display("store sw addr=0x3000 (ready delayed)");

        mem_wr = 1'b1; mem_rd = 1'b1; mem_type = 3'b001; addr = 32'h6002;
        wdata = 32'h1234ABCD;
        @(negedge clk);
        mem_wr = 1'b0; mem_rd = 1'b0;
        chk("sh_both_we", req_we_o, 1'b1);
        chk("sh_both_be", req_be_o, 4'b1100);
        chk("sh_both_wdata", req_wdata_o, 32'hABCDABCD);
        chk("sh_both_addr", req_addr_o, 32'h00006000);
        @(negedge clk);
        chk("sh_both_lvalid", load_valid_o, 1'b0);
        @(negedge clk);
        $display("store sh addr=0x6002 (rd+wr)");

`ifdef MISALIGN_TRAP_EN
        mem_rd = 1'b1; mem_type = 3'b010; addr = 32'h4002;
        #1;
        chk("lw_mis_idle_stall", stall_o, 1'b1);
        @(negedge clk);
        mem_rd = 1'b0;
        chk("lw_mis_req_valid", req_valid_o, 1'b0);
        chk("lw_mis_pulse", misalign_o, 1'b1);
        chk("lw_mis_lvalid", load_valid_o, 1'b0);
        chk("lw_mis_stall", stall_o, 1'b0);
        chk("lw_mis_hold", load_data_o, 32'hFFFFBEEF);
        @(negedge clk);
        chk("lw_mis_pulse_end", misalign_o, 1'b0);
        $display("load lw_mis addr=0x4002 trapped");
`else
        run_load("lw_mis", 3'b010, 32'h4002, 32'hCAFEF00D, 32'h4000, 4'b1111, 32'hCAFEF00D);
`endif

        mem_rd = 1'b1; mem_type = 3'b010; addr = 32'h5000; req_ready_i = 1'b1;
        @(negedge clk);
        mem_rd = 1'b0;
        chk("rw_req_valid", req_valid_o, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rw_rst_stall", stall_o, 1'b0);
        @(negedge clk);
        chk("rw_req_valid0", req_valid_o, 1'b0);
        chk("rw_req_addr0", req_addr_o, 32'h0);
        chk("rw_req_be0", req_be_o, 4'b0000);
        chk("rw_req_we0", req_we_o, 1'b0);
        chk("rw_load_data0", load_data_o, 32'h0);
        chk("rw_lvalid0", load_valid_o, 1'b0);
        rst = 1'b0; rsp_valid_i = 1'b1; rsp_rdata_i = 32'h11111111;
        #1;
        chk("rw_idle_stall", stall_o, 1'b0);
        @(negedge clk);
        rsp_valid_i = 1'b0;
        chk("rw_late_lvalid", load_valid_o, 1'b0);
        chk("rw_late_data", load_data_o, 32'h0);
        @(negedge clk);
        chk("rw_late_lvalid2", load_valid_o, 1'b0);
        $display("reset during wait addr=0x5000");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
